// File: rtl/rc_step_meas.sv
// Step-response stimulus/measurement FSM for the fixed-point RC model: drives a step, times rise/fall crossings.
// Optional macro RC_MEAS_TIMEOUT_EN bounds each RISE/FALL phase to TIMEOUT_CYCLES and flags `timeout`.
module rc_step_meas #(
  parameter int WIDTH          = 25,
  parameter int CNT_W          = 16,
  parameter int HOLD_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] v_high,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic [WIDTH-1:0] v_in,
  input  logic [WIDTH-1:0] v_out,
  output logic             busy,
  output logic [CNT_W-1:0] rise_cycles,
  output logic [CNT_W-1:0] fall_cycles,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout
);

  typedef enum logic [2:0] {S_IDLE, S_RISE, S_HOLD, S_FALL, S_REPORT} state_t;

`ifdef RC_MEAS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONES  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] v_high_q, v_high_d;
  logic signed [WIDTH-1:0] thr_hi_q, thr_hi_d;
  logic signed [WIDTH-1:0] thr_lo_q, thr_lo_d;
  logic signed [WIDTH-1:0] v_in_q, v_in_d;
  logic [CNT_W-1:0]        rise_q, rise_d;
  logic [CNT_W-1:0]        fall_q, fall_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;
  logic signed [WIDTH-1:0] v_out_s;

  // Model output goes straight into the compare; no sampling register on this path.
  assign v_out_s = $signed(v_out);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    v_high_d  = v_high_q;
    thr_hi_d  = thr_hi_q;
    thr_lo_d  = thr_lo_q;
    v_in_d    = v_in_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          v_high_d  = $signed(v_high);
          thr_hi_d  = $signed(thr_hi);
          thr_lo_d  = $signed(thr_lo);
          v_in_d    = $signed(v_high);
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = S_RISE;
        end
      end
      S_RISE: begin
        if (v_out_s >= thr_hi_q) begin
          rise_d  = cnt_q;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          // Rise never crossed: no fall phase is run, so both results are marked invalid.
          rise_d    = CNT_ONES;
          fall_d    = CNT_ONES;
          timeout_d = 1'b1;
          v_in_d    = '0;
          valid_d   = 1'b1;
          state_d   = S_REPORT;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          v_in_d  = '0;
          cnt_d   = '0;
          state_d = S_FALL;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_FALL: begin
        if (v_out_s <= thr_lo_q) begin
          fall_d  = cnt_q;
          valid_d = 1'b1;
          state_d = S_REPORT;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          fall_d    = CNT_ONES;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = S_REPORT;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_REPORT: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      v_high_q  <= '0;
      thr_hi_q  <= '0;
      thr_lo_q  <= '0;
      v_in_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      v_high_q  <= v_high_d;
      thr_hi_q  <= thr_hi_d;
      thr_lo_q  <= thr_lo_d;
      v_in_q    <= v_in_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign v_in         = v_in_q;
  assign busy         = busy_q;
  assign rise_cycles  = rise_q;
  assign fall_cycles  = fall_q;
  assign result_valid = valid_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/rc_step_meas.md
# rc_step_meas

Synthesizable step-response stimulus/measurement block: the digital-side counterpart of the fixed-point RC model. It drives the model's signed fixed-point input `v_in` with a programmable step, watches the model's fixed-point output `v_out`, and reports in clock cycles how long the output takes to cross a rise threshold and then a fall threshold. It replaces the real-valued testbench driver so the RC model can be characterised on FPGA emulation without `real` types.

## Interface
Parameters:
- `WIDTH`, 25, bit width of all fixed-point values; all share one exponent set by the integrator.
- `CNT_W`, 16, width of the cycle counters and results.
- `HOLD_CYCLES`, 256, cycles `v_in` stays high after the rise crossing; must be ≥1.
- `TIMEOUT_CYCLES`, 65535, max cycles per RISE/FALL phase; used only with `RC_MEAS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle measurement request.
- `v_high`  in  WIDTH  signed step amplitude; latched on accepted `start`.
- `thr_hi`  in  WIDTH  signed rise threshold; latched on accepted `start`.
- `thr_lo`  in  WIDTH  signed fall threshold; latched on accepted `start`.
- `v_in`  out  WIDTH  signed drive to the model input; registered.
- `v_out`  in  WIDTH  signed model output sample.
- `busy`  out  1  high in any state except IDLE.
- `rise_cycles`  out  CNT_W  measured rise time.
- `fall_cycles`  out  CNT_W  measured fall time.
- `result_valid`  out  1  results available.
- `result_ready`  in  1  consumer accepts results.
- `timeout`  out  1  qualifies results; phase did not cross.

## Operation
- States: IDLE, RISE, HOLD, FALL, REPORT.
- Reset values: state IDLE, `v_in`=0, `busy`=0, `rise_cycles`=0, `fall_cycles`=0, `result_valid`=0, `timeout`=0, latched thresholds/amplitude 0.
- IDLE: `start`=1 latches `v_high`/`thr_hi`/`thr_lo`, clears phase counter, and moves to RISE. `v_in` becomes `v_high` on the same edge. `start` in any other state is ignored.
- RISE: each cycle, if signed `v_out` ≥ latched `thr_hi`, store the counter into `rise_cycles` and go to HOLD. Otherwise increment the counter, saturating at all-ones.
- HOLD: count `HOLD_CYCLES` cycles with `v_in`=`v_high`. On the last one, go to FALL, drive `v_in`=0 and clear the counter.
- FALL: same as RISE with signed `v_out` ≤ latched `thr_lo`. The counter is stored into `fall_cycles`, then go to REPORT.
- REPORT: `result_valid`=1. Results and `timeout` are stable until `result_ready`=1. On that cycle go to IDLE and `result_valid` deasserts on the next edge.
- Comparisons are full-width signed. No scaling or rounding is performed; the amplitude is passed through bit-exact.
- Any asynchronous reset assertion mid-measurement returns all outputs to reset values immediately, including `v_in`=0.

## Timing
- Latency from `start` to `v_in` change: 1 edge.
- Counter semantics: `v_out` already past the threshold in the first RISE cycle gives `rise_cycles`=0. A crossing in the Nth RISE cycle gives N-1.
- `v_out` is sampled combinationally into the compare, with no input register. The integrator registers it if the model path is long.
- From the rise crossing, `v_in` falls after exactly `HOLD_CYCLES`+1 edges.
- `result_valid` rises one edge after the fall crossing.
- `busy` is high from the edge after `start` until the REPORT→IDLE edge.

## Configuration
- `RC_MEAS_TIMEOUT_EN` defined:
  - If the RISE or FALL counter reaches `TIMEOUT_CYCLES` without a crossing, store all-ones into that phase's result.
  - Set `timeout`=1 and drive `v_in`=0.
  - Go directly to REPORT; a rise timeout skips HOLD/FALL and sets `fall_cycles` to all-ones.
- `RC_MEAS_TIMEOUT_EN` not defined:
  - The counters saturate and the FSM waits indefinitely.
  - `timeout` is tied to 0.

## Test plan
- Basic:
  - Stimulus: `v_high`=1000, `thr_hi`=632, `thr_lo`=368, `HOLD_CYCLES`=4. Bench holds `v_out`=0, raises it to 700 in the 6th RISE cycle, and drops it to 300 in the 3rd FALL cycle.
  - Required response: `rise_cycles`=5, `fall_cycles`=2, `timeout`=0, `v_in` sequence 0→1000→0.
- Immediate crossing: `v_out`=800 at `start`, `thr_hi`=632 → `rise_cycles`=0. HOLD then lasts exactly `HOLD_CYCLES`+1 edges until `v_in`=0.
- Handshake: hold `result_ready`=0 for 10 cycles in REPORT and pulse `start` → results stable, `start` ignored, `busy`=1. Then `result_ready`=1 → IDLE next edge and `busy`=0.
- Signed: `v_high`=-500, `thr_hi`=-600, `thr_lo`=-700, with `v_out` ramping from -800 → rise detected at -600 and fall at ≤-700, with correct signed compares.
- Reset mid-HOLD: assert `rst`=0 asynchronously between edges → `v_in`=0, `busy`=0, `result_valid`=0 immediately. A new `start` after release measures normally.
- Timeout (macro defined, `TIMEOUT_CYCLES`=20): `v_out` stuck at 0 → REPORT after 20 RISE cycles with `timeout`=1, `rise_cycles`=`fall_cycles`=16'hFFFF, `v_in`=0. Without the macro, `busy` stays 1 after 100 cycles.
